// File: rtl/djpeg_idct_buf_reader_if.sv
// Read port of the IDCT transpose buffer plus the beat stream into the second
// 1-D IDCT pass; master is the reader, slave is the buffer/downstream side.
interface djpeg_idct_buf_reader_if #(
    parameter int DATA_W = 16
);
    logic              buf_enable;
    logic              buf_read;
    logic [4:0]        buf_address;
    logic [DATA_W-1:0] buf_data_a;
    logic [DATA_W-1:0] buf_data_b;

    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_page;
    logic [1:0]        out_count;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              out_last;

    modport master (
        input  buf_enable, buf_data_a, buf_data_b, out_ready,
        output buf_read, buf_address, out_valid, out_page, out_count,
               out_a, out_b, out_last
    );

    modport slave (
        output buf_enable, buf_data_a, buf_data_b, out_ready,
        input  buf_read, buf_address, out_valid, out_page, out_count,
               out_a, out_b, out_last
    );
endinterface

// File: rtl/djpeg_idct_buf_reader.sv
// Read-side sequencer for the IDCT transpose buffer: sweeps addresses 0..31 of a
// full bank, un-swaps the returned lanes and streams them through a skid FIFO.
module djpeg_idct_buf_reader #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init,
    djpeg_idct_buf_reader_if.master bus,
    output logic                   idle
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = CNT_W + 2;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } beat_t;

    state_t            state_q, state_d;
    logic              rd_q, rd_d;
    logic [4:0]        addr_q, addr_d;
    logic              pend_q;
    logic [4:0]        pend_addr_q;

    beat_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              push, pop, has_room, swap;
    logic [CRD_W-1:0]  credit;
    beat_t             cap_beat, head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = pend_q && !init;
    assign pop  = bus.out_valid && bus.out_ready;

    // Credit covers stored entries plus both pipeline stages, so an issue is
    // only made when its pair is guaranteed a slot when it lands.
    assign credit   = CRD_W'(count_q) + CRD_W'(rd_q) + CRD_W'(pend_q) - CRD_W'(pop);
    assign has_room = credit < CRD_W'(FIFO_DEPTH);

    // The buffer mirrors lanes on its current address[4]; undo that when the
    // address has since crossed the half boundary.
    assign swap          = addr_q[4] ^ pend_addr_q[4];
    assign cap_beat.addr = pend_addr_q;
    assign cap_beat.a    = swap ? bus.buf_data_b : bus.buf_data_a;
    assign cap_beat.b    = swap ? bus.buf_data_a : bus.buf_data_b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        if (init) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Waiting out the cycle that drives address 31 gives the
                    // buffer time to retire its read bank before buf_enable is trusted.
                    if (bus.buf_enable && !rd_q && has_room) begin
                        state_d = S_RUN;
                        rd_d    = 1'b1;
                        addr_d  = '0;
                    end
                end
                S_RUN: begin
                    if (has_room) begin
                        rd_d   = 1'b1;
                        addr_d = addr_q + 5'd1;
                        if (addr_q == 5'd30) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            pend_q      <= rd_q && !init;
            pend_addr_q <= addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (init) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count make stale entries unobservable.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cap_beat;
    end

    assign head            = fifo_mem[rd_ptr_q];
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_page    = bus.out_valid ? head.addr[4:2] : 3'd0;
    assign bus.out_count   = bus.out_valid ? head.addr[1:0] : 2'd0;
    assign bus.out_a       = bus.out_valid ? head.a : '0;
    assign bus.out_b       = bus.out_valid ? head.b : '0;
    assign bus.out_last    = bus.out_valid && (head.addr == 5'd31);
    assign bus.buf_read    = rd_q;
    assign bus.buf_address = addr_q;
    assign idle            = (state_q == S_IDLE) && (count_q == '0);
endmodule
